ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_line_filter.sv | 57 +++++
 rtl/ps2_key_decoder.sv | 171 +++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder: FSM state
// encoding, scancode prefix bytes and the keyboard status bytes that are
// dropped instead of being reported as key events.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PFX_EXT   = 8'hE0;
   localparam logic [7:0] PFX_REL   = 8'hF0;
   localparam logic [7:0] PFX_PAUSE = 8'hE1;

   // Bytes following the Pause prefix that are swallowed without effect
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   // Keyboard status / acknowledge bytes that never represent a key
   localparam logic [7:0] IGN_ERR0   = 8'h00;
   localparam logic [7:0] IGN_BAT_OK = 8'hAA;
   localparam logic [7:0] IGN_ECHO   = 8'hEE;
   localparam logic [7:0] IGN_ACK    = 8'hFA;
   localparam logic [7:0] IGN_BAT_E1 = 8'hFC;
   localparam logic [7:0] IGN_BAT_E2 = 8'hFD;
   localparam logic [7:0] IGN_RESEND = 8'hFE;
   localparam logic [7:0] IGN_ERR1   = 8'hFF;

   function automatic logic is_ignored(input logic [7:0] b);
      return b inside {IGN_ERR0, IGN_BAT_OK, IGN_ECHO, IGN_ACK,
                       IGN_BAT_E1, IGN_BAT_E2, IGN_RESEND, IGN_ERR1};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Brings one asynchronous PS/2 line into the clk_sys domain and debounces
// it: the filtered level only follows the synchronized level after they
// have disagreed for FILTER_LEN consecutive cycles. A one-cycle fall
// strobe marks the first cycle in which the filtered level reads 0.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic line_in,
   output logic sync_out,
   output logic level_out,
   output logic fall_out
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [1:0]       sync_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fall_q, fall_d;

   // Debounce: count disagreeing cycles, flip the level on the last one
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      fall_d = level_q & ~level_d;
   end

   // Synchronizer, filtered level and strobe; idle-high so reset release is edge-free
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         cnt_q   <= '0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], line_in};
         level_q <= level_d;
         cnt_q   <= cnt_d;
         fall_q  <= fall_d;
      end
   end

   assign sync_out  = sync_q[1];
   assign level_out = level_q;
   assign fall_out  = fall_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames 11-bit serial words on the filtered clock
// falling edge, checks parity and stop bit, strips prefix/status bytes and
// presents one key event at a time on ps2_key with a toggling event bit.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk_in,
   input  logic        ps2_dat_in,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic clk_sync, clk_level, clk_fall;
   logic dat_sync, dat_level, dat_fall;
   logic unused_ok;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .line_in   (ps2_clk_in),
      .sync_out  (clk_sync),
      .level_out (clk_level),
      .fall_out  (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .line_in   (ps2_dat_in),
      .sync_out  (dat_sync),
      .level_out (dat_level),
      .fall_out  (dat_fall)
   );

   // Only the clock strobe and the synchronized data level drive the decoder
   assign unused_ok = &{1'b0, clk_sync, clk_level, dat_level, dat_fall};

   ps2_state_e       state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_ok_q, par_ok_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             ext_q, ext_d;
   logic             rel_q, rel_d;
   logic [2:0]       skip_q, skip_d;
   logic [10:0]      key_q, key_d;
   logic             frame_err_q, frame_err_d;

   logic start_bit, shift_en, parity_en, stop_en, timeout;
   logic byte_ok, byte_bad;

   // FSM state register
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: walk start/data/parity/stop, abandon the frame on timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_bit) state_d = DATA;
         DATA:    if (shift_en && bit_cnt_q == 3'd7) state_d = PARITY;
         PARITY:  if (parity_en) state_d = STOP;
         STOP:    if (stop_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (timeout) state_d = IDLE;
   end

   // FSM outputs: which frame field the current sample point belongs to
   always_comb begin
      start_bit = (state_q == IDLE) && clk_fall && !dat_sync;
      shift_en  = (state_q == DATA) && clk_fall;
      parity_en = (state_q == PARITY) && clk_fall;
      stop_en   = (state_q == STOP) && clk_fall;
      timeout   = (state_q != IDLE) && !clk_fall && (to_cnt_q == TO_LAST);
      byte_ok   = stop_en && dat_sync && par_ok_q;
      byte_bad  = stop_en && !(dat_sync && par_ok_q);
   end

   // Datapath: bit assembly, timeout counting, prefix tracking and key output
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_ok_d    = par_ok_q;
      to_cnt_d    = to_cnt_q;
      ext_d       = ext_q;
      rel_d       = rel_q;
      skip_d      = skip_q;
      key_d       = key_q;
      frame_err_d = 1'b0;

      if (start_bit) bit_cnt_d = 3'd0;
      if (shift_en) begin
         shift_d   = {dat_sync, shift_q[7:1]};
         bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (parity_en) par_ok_d = ^{shift_q, dat_sync};

      if (state_q == IDLE || clk_fall || timeout) begin
         to_cnt_d = '0;
      end else begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end

      if (byte_bad || timeout) begin
         frame_err_d = 1'b1;
         ext_d       = 1'b0;
         rel_d       = 1'b0;
      end

      if (byte_ok) begin
         if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
         end else if (shift_q == PFX_PAUSE) begin
            skip_d = PAUSE_SKIP;
         end else if (shift_q == PFX_EXT) begin
            ext_d = 1'b1;
         end else if (shift_q == PFX_REL) begin
            rel_d = 1'b1;
         end else if (!ext_q && !rel_q && is_ignored(shift_q)) begin
            skip_d = skip_q;
         end else begin
            key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
            ext_d = 1'b0;
            rel_d = 1'b0;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_ok_q    <= 1'b0;
         to_cnt_q    <= '0;
         ext_q       <= 1'b0;
         rel_q       <= 1'b0;
         skip_q      <= '0;
         key_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_ok_q    <= par_ok_d;
         to_cnt_q    <= to_cnt_d;
         ext_q       <= ext_d;
         rel_q       <= rel_d;
         skip_q      <= skip_d;
         key_q       <= key_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign ps2_key   = key_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a driver serializes PS/2 frames
// and asks a byte-level keyboard model what should come out; a monitor
// pops those expectations whenever the DUT reports an event or an error.
module tb_ps2_key_decoder;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 2000;
   localparam int HALF        = 30;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk_in = 1'b1;
   logic        ps2_dat_in = 1'b1;
   logic [10:0] ps2_key;
   logic        frame_err;

   typedef struct packed {
      logic        is_err;
      logic [10:0] key;
   } expect_t;

   expect_t     exp_q[$];
   int          checks_total = 0;
   int          checks_passed = 0;

   logic        m_ext = 1'b0;
   logic        m_rel = 1'b0;
   int          m_skip = 0;
   logic        m_tog = 1'b0;
   logic [10:0] prev_key = '0;

   ps2_key_decoder #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_key    (ps2_key),
      .frame_err  (frame_err)
   );

   // System clock
   always #5 clk_sys = ~clk_sys;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   // Keyboard model: what the byte stream means, one accepted byte at a time
   task automatic modelByte(input logic [7:0] b);
      expect_t e;
      if (m_skip > 0) begin
         m_skip--;
      end else if (b == 8'hE1) begin
         m_skip = 7;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_rel = 1'b1;
      end else if (!m_ext && !m_rel &&
                   (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
         m_skip = 0;
      end else begin
         m_tog    = ~m_tog;
         e.is_err = 1'b0;
         e.key    = {m_tog, ~m_rel, m_ext, b};
         exp_q.push_back(e);
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic modelError();
      expect_t e;
      e.is_err = 1'b1;
      e.key    = '0;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_rel = 1'b0;
   endtask

   task automatic modelReset();
      m_ext  = 1'b0;
      m_rel  = 1'b0;
      m_skip = 0;
      m_tog  = 1'b0;
   endtask

   // One PS/2 bit cell; optional short clock glitches in both phases
   task automatic driveBit(input logic b, input logic glitch);
      ps2_dat_in = b;
      if (glitch) begin
         waitCycles(3);
         ps2_clk_in = 1'b0;
         waitCycles(4);
         ps2_clk_in = 1'b1;
         waitCycles(HALF / 2 - 7);
      end else begin
         waitCycles(HALF / 2);
      end
      ps2_clk_in = 1'b0;
      if (glitch) begin
         waitCycles(18);
         ps2_clk_in = 1'b1;
         waitCycles(4);
         ps2_clk_in = 1'b0;
         waitCycles(HALF - 22);
      end else begin
         waitCycles(HALF);
      end
      ps2_clk_in = 1'b1;
      waitCycles(HALF / 2);
   endtask

   // Full frame; the model is told the outcome before the wire sees it
   task automatic applyStimulus(input logic [7:0] b, input logic bad_par,
                                input logic bad_stop, input logic glitch);
      logic par;
      par = ~(^b) ^ bad_par;
      if (bad_par || bad_stop) modelError();
      else modelByte(b);
      driveBit(1'b0, glitch);
      for (int i = 0; i < 8; i++) driveBit(b[i], glitch);
      driveBit(par, glitch);
      driveBit(~bad_stop, glitch);
      ps2_dat_in = 1'b1;
      waitCycles(60);
   endtask

   // Start bit plus n data bits, then the line is left idle
   task automatic sendPartial(input logic [7:0] b, input int n);
      driveBit(1'b0, 1'b0);
      for (int i = 0; i < n; i++) driveBit(b[i], 1'b0);
      ps2_dat_in = 1'b1;
   endtask

   // Monitor: every DUT event or error must match the head of the scoreboard
   always @(negedge clk_sys) begin
      expect_t e;
      if (reset) begin
         prev_key = ps2_key;
      end else begin
         if (frame_err && ps2_key != prev_key) begin
            checkOutput("err_with_event", {31'd0, frame_err}, 32'd0);
         end
         if (frame_err || ps2_key != prev_key) begin
            if (exp_q.size() == 0) begin
               checks_total++;
               $display("[TB] FAIL unexpected_output: key %0h err %0b, nothing expected", ps2_key, frame_err);
            end else begin
               e = exp_q.pop_front();
               checkOutput("output_kind", {31'd0, frame_err}, {31'd0, e.is_err});
               if (!e.is_err) checkOutput("event_key", {21'd0, ps2_key}, {21'd0, e.key});
            end
         end
         prev_key = ps2_key;
      end
   end

   logic [7:0] ign_list [8];
   logic [7:0] pause_seq [8];

   initial begin
      logic [7:0] b;
      int r;
      ign_list  = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

      waitCycles(10);
      checkOutput("reset_key", {21'd0, ps2_key}, 32'd0);
      checkOutput("reset_err", {31'd0, frame_err}, 32'd0);
      reset = 1'b0;
      waitCycles(50);

      $display("[TB] single make code");
      applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);

      $display("[TB] extended break code");
      applyStimulus(8'hE0, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h75, 1'b0, 1'b0, 1'b0);

      $display("[TB] parity error then recovery");
      applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);

      $display("[TB] timeout on partial frame");
      modelError();
      sendPartial(8'h29, 4);
      waitCycles(TIMEOUT_CYC + 200);
      applyStimulus(8'h29, 1'b0, 1'b0, 1'b0);

      $display("[TB] pause sequence");
      for (int i = 0; i < 8; i++) applyStimulus(pause_seq[i], 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0);

      $display("[TB] glitched clock and bad stop bit");
      applyStimulus(8'h3B, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h4D, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h4D, 1'b0, 1'b0, 1'b0);

      $display("[TB] random byte stream");
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 19);
         if (r < 3) b = 8'hE0;
         else if (r < 6) b = 8'hF0;
         else if (r == 6) b = 8'hE1;
         else if (r < 10) b = ign_list[$urandom_range(0, 7)];
         else b = 8'($urandom);
         applyStimulus(b, ($urandom_range(0, 11) == 0), 1'b0, 1'b0);
      end
      waitCycles(100);

      $display("[TB] reset in mid frame");
      sendPartial(8'h66, 3);
      reset = 1'b1;
      waitCycles(5);
      checkOutput("midreset_key", {21'd0, ps2_key}, 32'd0);
      checkOutput("midreset_err", {31'd0, frame_err}, 32'd0);
      modelReset();
      ps2_clk_in = 1'b1;
      ps2_dat_in = 1'b1;
      waitCycles(5);
      reset = 1'b0;
      waitCycles(50);
      applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);

      waitCycles(200);
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
